// File: rtl/cmul_seq_ctrl_pkg.sv
// cmul_seq_ctrl_pkg: shared state encoding, step count and result width for the
// sequential complex multiplier. Step count follows CMUL_GAUSS_EN.
`default_nettype none

package cmul_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned STEP_W = 2;

`ifdef CMUL_GAUSS_EN
  localparam int unsigned STEPS = 3;
`else
  localparam int unsigned STEPS = 4;
`endif

  function automatic int res_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmul_real_mult.sv
// cmul_real_mult: combinational signed (W+1)x(W+1) -> 2W+2 multiplier,
// the single shared multiplier of cmul_seq_ctrl.
`default_nettype none

module cmul_real_mult #(
  parameter int W = 8
) (
  input  logic signed [W:0]     a,
  input  logic signed [W:0]     b,
  output logic signed [2*W+1:0] p
);

  assign p = a * b;

endmodule

`default_nettype wire

// File: rtl/cmul_seq_ctrl.sv
// cmul_seq_ctrl: complex product over a time-shared real multiplier; 4-multiply
// schedule by default, 3-multiply (Gauss) schedule when CMUL_GAUSS_EN is defined.
`default_nettype none

module cmul_seq_ctrl
  import cmul_seq_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          ar,
  input  logic [W-1:0]          ai,
  input  logic [W-1:0]          br,
  input  logic [W-1:0]          bi,
  output logic                  busy,
  output logic                  done,
  output logic [res_w(W)-1:0]   pr,
  output logic [res_w(W)-1:0]   pi
);

  localparam int RW = res_w(W);
  localparam int AW = 2 * W + 2;

  state_t                state, state_nxt;
  logic [STEP_W-1:0]     step;
  logic [W-1:0]          ar_q, ai_q, br_q, bi_q;
  logic signed [AW-1:0]  acc_r, acc_i, acc_r_nxt, acc_i_nxt, prod;
  logic signed [W:0]     mul_a, mul_b;
  logic                  accept, last;

  function automatic logic signed [W:0] sx(input logic [W-1:0] v);
    return {v[W-1], v};
  endfunction

  // DONE accepts a new start just like IDLE, giving back-to-back operation.
  assign accept = start && (state != MUL);
  assign last   = (state == MUL) && (step == STEP_W'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = MUL;
      MUL: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? MUL : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand selection for the shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state == MUL) begin
`ifdef CMUL_GAUSS_EN
      case (step)
        2'd0:    begin mul_a = sx(br_q); mul_b = sx(ar_q) + sx(ai_q); end
        2'd1:    begin mul_a = sx(ar_q); mul_b = sx(bi_q) - sx(br_q); end
        default: begin mul_a = sx(ai_q); mul_b = sx(br_q) + sx(bi_q); end
      endcase
`else
      case (step)
        2'd0:    begin mul_a = sx(ar_q); mul_b = sx(br_q); end
        2'd1:    begin mul_a = sx(ai_q); mul_b = sx(bi_q); end
        2'd2:    begin mul_a = sx(ar_q); mul_b = sx(bi_q); end
        default: begin mul_a = sx(ai_q); mul_b = sx(br_q); end
      endcase
`endif
    end
  end

  cmul_real_mult #(.W(W)) u_mult (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // Accumulation of the current partial product.
  always_comb begin
    acc_r_nxt = acc_r;
    acc_i_nxt = acc_i;
    if (state == MUL) begin
`ifdef CMUL_GAUSS_EN
      case (step)
        2'd0: begin
          acc_r_nxt = acc_r + prod;
          acc_i_nxt = acc_i + prod;
        end
        2'd1:    acc_i_nxt = acc_i + prod;
        default: acc_r_nxt = acc_r - prod;
      endcase
`else
      case (step)
        2'd0:    acc_r_nxt = acc_r + prod;
        2'd1:    acc_r_nxt = acc_r - prod;
        2'd2:    acc_i_nxt = acc_i + prod;
        default: acc_i_nxt = acc_i + prod;
      endcase
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step  <= '0;
      ar_q  <= '0;
      ai_q  <= '0;
      br_q  <= '0;
      bi_q  <= '0;
      acc_r <= '0;
      acc_i <= '0;
      pr    <= '0;
      pi    <= '0;
    end else if (accept) begin
      step  <= '0;
      ar_q  <= ar;
      ai_q  <= ai;
      br_q  <= br;
      bi_q  <= bi;
      acc_r <= '0;
      acc_i <= '0;
    end else if (state == MUL) begin
      step  <= step + STEP_W'(1);
      acc_r <= acc_r_nxt;
      acc_i <= acc_i_nxt;
      // Results are loaded with the final partial sum so they are valid in DONE.
      if (last) begin
        pr <= acc_r_nxt[RW-1:0];
        pi <= acc_i_nxt[RW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmul_seq_ctrl.sv
// tb_cmul_seq_ctrl: table vectors plus corner sequences on a W=8 instance with a
// result scoreboard, and an exhaustive operand sweep on a W=2 instance.
`default_nettype none

module tb_cmul_seq_ctrl;

`ifdef CMUL_GAUSS_EN
  localparam int N_STEPS = 3;
`else
  localparam int N_STEPS = 4;
`endif
  localparam int LAT = N_STEPS + 1;  // negedges after accept edge until done visible

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] ar = '0, ai = '0, br = '0, bi = '0;
  logic busy, done;
  logic [16:0] pr, pi;

  logic start2 = 1'b0;
  logic [1:0] ar2 = '0, ai2 = '0, br2 = '0, bi2 = '0;
  logic busy2, done2;
  logic [4:0] pr2, pi2;

  cmul_seq_ctrl #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ar(ar), .ai(ai), .br(br), .bi(bi),
    .busy(busy), .done(done), .pr(pr), .pi(pi)
  );

  cmul_seq_ctrl #(.W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .ar(ar2), .ai(ai2), .br(br2), .bi(bi2),
    .busy(busy2), .done(done2), .pr(pr2), .pi(pi2)
  );

  always #5 clk = ~clk;

  typedef struct { int pr; int pi; } res_t;
  typedef struct { int ar; int ai; int br; int bi; int epr; int epi; } vec_t;

  int   n_tests = 0, n_fail = 0;
  res_t sb[$];
  int   done_cyc[$];
  int   done_cnt = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t gold(input int a, input int b, input int c, input int d);
    res_t r;
    r.pr = a * c - b * d;
    r.pi = a * d + b * c;
    return r;
  endfunction

  task automatic drive(input int a, input int b, input int c, input int d);
    ar = 8'(a); ai = 8'(b); br = 8'(c); bi = 8'(d);
  endtask

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    res_t e;
    if (done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      check(!prev_done, "done_not_consecutive", longint'(prev_done), 0);
      check(!busy, "busy_low_with_done", longint'(busy), 0);
      if (sb.size() == 0) begin
        check(1'b0, "unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check($signed(pr) == e.pr, "pr", $signed(pr), e.pr);
        check($signed(pi) == e.pi, "pi", $signed(pi), e.pi);
      end
    end
    prev_done = done;
  end

  task automatic run_op(input vec_t v);
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    drive(v.ar, v.ai, v.br, v.bi);
    sb.push_back('{v.epr, v.epi});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check(busy == 1'b1, "busy_after_accept", longint'(busy), 1);
    seen = done;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      seen = done;
    end
    check(seen && n == LAT, "latency", n, LAT);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[8];
    vec_t bb[3];
    res_t g;
    int   n, d0;
    bit   seen;

    vt[0] = '{3, 4, 5, 6, -9, 38};
    vt[1] = '{-128, -128, -128, -128, 0, 32768};
    vt[2] = '{-128, 127, 127, -128, 0, 32513};
    vt[3] = '{1, 1, 1, -1, 2, 0};
    vt[4] = '{-1, 0, 0, 1, 0, -1};
    vt[5] = '{127, 127, 127, 127, 0, 32258};
    vt[6] = '{-128, 0, -128, 0, 16384, 0};
    vt[7] = '{5, -7, -3, 2, -1, 31};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(busy == 1'b0, "reset_busy", longint'(busy), 0);
    check(done == 1'b0, "reset_done", longint'(done), 0);
    check(pr == '0, "reset_pr", longint'(pr), 0);
    check(pi == '0, "reset_pi", longint'(pi), 0);
    rst = 1'b0;

    foreach (vt[i]) run_op(vt[i]);

    // start pulsed during every busy cycle must be ignored
    @(negedge clk);
    start = 1'b1;
    drive(3, 4, 5, 6);
    sb.push_back('{-9, 38});
    d0 = done_cnt;
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      seen = done;
      if (busy) begin
        start = 1'b1;
        drive(int'($signed(8'($urandom))), int'($signed(8'($urandom))),
              int'($signed(8'($urandom))), int'($signed(8'($urandom))));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    check(done_cnt - d0 == 1, "ignore_start_one_done", done_cnt - d0, 1);

    // start held high: back-to-back operations
    for (int k = 0; k < 3; k++) begin
      bb[k].ar = int'($signed(8'($urandom)));
      bb[k].ai = int'($signed(8'($urandom)));
      bb[k].br = int'($signed(8'($urandom)));
      bb[k].bi = int'($signed(8'($urandom)));
    end
    done_cyc.delete();
    @(negedge clk);
    start = 1'b1;
    drive(bb[0].ar, bb[0].ai, bb[0].br, bb[0].bi);
    g = gold(bb[0].ar, bb[0].ai, bb[0].br, bb[0].bi);
    sb.push_back(g);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < 2) begin
        drive(bb[k+1].ar, bb[k+1].ai, bb[k+1].br, bb[k+1].bi);
        g = gold(bb[k+1].ar, bb[k+1].ai, bb[k+1].br, bb[k+1].bi);
        sb.push_back(g);
        repeat (LAT - 1) @(posedge clk);
      end else begin
        start = 1'b0;
      end
    end
    n = 0;
    while (done_cyc.size() < 3 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(done_cyc.size() == 3, "b2b_done_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check(done_cyc[1] - done_cyc[0] == LAT, "b2b_period_1", done_cyc[1] - done_cyc[0], LAT);
      check(done_cyc[2] - done_cyc[1] == LAT, "b2b_period_2", done_cyc[2] - done_cyc[1], LAT);
    end

    // Reset two cycles into MUL abandons the operation
    repeat (2) @(negedge clk);
    start = 1'b1;
    drive(7, -3, 2, 9);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check(busy == 1'b0, "midrst_busy", longint'(busy), 0);
    check(done == 1'b0, "midrst_done", longint'(done), 0);
    check(pr == '0, "midrst_pr", longint'(pr), 0);
    check(pi == '0, "midrst_pi", longint'(pi), 0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    check(done_cnt == d0, "midrst_no_done", done_cnt - d0, 0);
    run_op(vt[3]);

    // Exhaustive sweep on the W=2 instance
    for (int a = -2; a < 2; a++)
      for (int b = -2; b < 2; b++)
        for (int c = -2; c < 2; c++)
          for (int d = -2; d < 2; d++) begin
            g = gold(a, b, c, d);
            @(negedge clk);
            start2 = 1'b1;
            ar2 = 2'(a); ai2 = 2'(b); br2 = 2'(c); bi2 = 2'(d);
            @(posedge clk);
            @(negedge clk);
            start2 = 1'b0;
            n = 1;
            while (!done2 && n < 20) begin
              @(negedge clk);
              n++;
            end
            if (!done2) begin
              check(1'b0, "sweep_timeout", n, LAT);
            end else begin
              check($signed(pr2) == g.pr, "sweep_pr", $signed(pr2), g.pr);
              check($signed(pi2) == g.pi, "sweep_pi", $signed(pi2), g.pi);
            end
          end

    repeat (3) @(negedge clk);
    check(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
